// File: rtl/transfer_frame_tx.sv
// ----------------------------------------------------------------------------
// transfer_frame_tx
//
// Serialiser that feeds the transfer center's single-bit dataIn line.
// Traffic is sent MSB-first in fixed 8-clock byte slots. The slots are aligned
// to reset. Two kinds of traffic share the line:
//   - one-byte buffer-status/control commands (codes 1..6)
//   - data bursts: a header byte (7 = binary, 8 = ASCII) followed by up to
//     MAX_BURST payload bytes, which are drained from an internal byte FIFO
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   cmd_valid    command request
//   cmd_code     command code, 1..6 legal (0 and 7 are sent as 0x00)
//   cmd_ready    high in the IDLE slot-load cycle; accepts a command when
//                cmd_valid is also high
//   data_in      payload byte
//   data_valid   payload byte offered
//   data_ready   FIFO has room for a byte
//   data_ascii   header select (0 -> 0x07, 1 -> 0x08), sampled at header load
//   tx_enable    downstream ready; needed only to start a burst
//   serial_out   serial line (MSB of the shift register)
//   byte_strobe  high during the last bit of every slot
//   frame_state  00 IDLE, 01 PAYLOAD
//   fifo_count   number of bytes held in the FIFO
// ----------------------------------------------------------------------------
module transfer_frame_tx #(
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd_code,
  output logic                   cmd_ready,
  input  logic [7:0]             data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic                   data_ascii,
  input  logic                   tx_enable,
  output logic                   serial_out,
  output logic                   byte_strobe,
  output logic [1:0]             frame_state,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_B = CW'(MAX_BURST);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PAYLOAD = 2'b01
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shreg;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_burst_rem;

  logic            w_slot;
  logic            w_push;
  logic            w_pop;
  logic            w_start_burst;
  logic [7:0]      w_load_byte;
  logic [CW-1:0]   w_burst_len;

  // The last bit of a slot is also the cycle in which the next byte is chosen.
  assign w_slot      = (r_bit_cnt == 3'd7);
  assign w_push      = data_valid && data_ready;
  assign w_burst_len = (r_count > MAX_B) ? MAX_B : r_count;

  assign serial_out  = r_shreg[7];
  assign byte_strobe = w_slot;
  assign frame_state = r_state;
  assign fifo_count  = r_count;
  assign data_ready  = !rst && (r_count < FULL);
  // Commands are offered only at an IDLE slot boundary, so a burst always
  // finishes before a command can be accepted.
  assign cmd_ready   = !rst && (r_state == ST_IDLE) && w_slot;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Slot-load decision. Commands take priority over starting a burst.
  // Illegal codes 0 and 7 are sent as 0x00 so that they are never mistaken
  // for a data header.
  always_comb begin
    w_next_state  = r_state;
    w_load_byte   = 8'h00;
    w_pop         = 1'b0;
    w_start_burst = 1'b0;
    if (w_slot) begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            w_load_byte = ((cmd_code != 3'd0) && (cmd_code != 3'd7)) ?
                          {5'b00000, cmd_code} : 8'h00;
          end else if (tx_enable && (r_count != '0)) begin
            w_load_byte   = data_ascii ? 8'd8 : 8'd7;
            w_start_burst = 1'b1;
            w_next_state  = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          w_load_byte = r_mem[r_rd_ptr];
          w_pop       = 1'b1;
          if (r_burst_rem == CW'(1)) begin
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Slot timing, shift register, FIFO pointers and burst length.
  // The burst length is fixed when the header is loaded. Bytes pushed after
  // that point wait for the next burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= 3'd0;
      r_shreg     <= 8'h00;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_burst_rem <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_slot) begin
        r_shreg <= w_load_byte;
      end else begin
        r_shreg <= {r_shreg[6:0], 1'b0};
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_start_burst) begin
        r_burst_rem <= w_burst_len;
      end else if (w_pop) begin
        r_burst_rem <= r_burst_rem - CW'(1);
      end
    end
  end

  // Payload storage. Reset only clears the pointers; stale data is unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_transfer_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_transfer_frame_tx
//
// Bench for transfer_frame_tx. The reference model works at the level of
// byte slots. It tracks:
//   - a cycle count since reset (slot position = count mod 8)
//   - the byte currently on the line
//   - a queue that mirrors the payload FIFO
//   - the number of payload bytes left in the current burst
// Serial bits are also reassembled into bytes, independently of the model, so
// that the directed scenarios can check whole slots against constant lists.
// ----------------------------------------------------------------------------
module tb_transfer_frame_tx;

  localparam int DEPTH     = 8;
  localparam int MAX_BURST = 4;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       data_ascii;
  logic       tx_enable;
  logic       serial_out;
  logic       byte_strobe;
  logic [1:0] frame_state;
  logic [3:0] fifo_count;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int         mCyc;
  logic [7:0] mCur;
  logic [7:0] mQ[$];
  int         mBurst;

  // Observed line traffic.
  logic [7:0] acc;
  logic [7:0] obs[$];
  int         strobeCount;
  int         firstStrobe;
  int         acceptCount;
  int         firstAccept;

  typedef struct {
    logic [2:0] code;
    logic [7:0] expByte;
  } cmdVec_t;

  cmdVec_t cmdTable[8];

  transfer_frame_tx #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_ready   (cmd_ready),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data_ascii  (data_ascii),
    .tx_enable   (tx_enable),
    .serial_out  (serial_out),
    .byte_strobe (byte_strobe),
    .frame_state (frame_state),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d",
               name, $time, actual, expected);
    end
  endtask

  // Drives one clock cycle of inputs. Outputs are checked against the model
  // at the falling edge, and then the model is advanced across the rising edge.
  task automatic applyStimulus(input bit cv, input logic [2:0] cc, input bit dv,
                               input logic [7:0] di, input bit asc, input bit te);
    int         pos;
    int         sz;
    logic [7:0] nb;
    cmd_valid  = cv;
    cmd_code   = cc;
    data_valid = dv;
    data_in    = di;
    data_ascii = asc;
    tx_enable  = te;
    @(negedge clk);
    pos = mCyc % 8;
    sz  = mQ.size();
    checkOutput("serial_out",  serial_out,  mCur[7-pos]);
    checkOutput("byte_strobe", byte_strobe, pos == 7);
    checkOutput("frame_state", frame_state, (mBurst > 0) ? 1 : 0);
    checkOutput("fifo_count",  fifo_count,  sz);
    checkOutput("cmd_ready",   cmd_ready,   (pos == 7) && (mBurst == 0));
    checkOutput("data_ready",  data_ready,  sz < DEPTH);

    acc = {acc[6:0], serial_out};
    if (byte_strobe) begin
      if (firstStrobe < 0) firstStrobe = mCyc;
      strobeCount++;
    end
    if (cmd_ready && cmd_valid) begin
      if (firstAccept < 0) firstAccept = mCyc;
      acceptCount++;
    end
    if (pos == 7) obs.push_back(acc);

    // Choose the next slot byte. The choice uses the queue as it stands
    // before this cycle's push.
    if (pos == 7) begin
      if (mBurst > 0) begin
        nb = mQ.pop_front();
        mBurst--;
      end else if (cv) begin
        nb = (cc >= 3'd1 && cc <= 3'd6) ? {5'b00000, cc} : 8'h00;
      end else if (te && sz > 0) begin
        nb     = asc ? 8'd8 : 8'd7;
        mBurst = (sz < MAX_BURST) ? sz : MAX_BURST;
      end else begin
        nb = 8'h00;
      end
      mCur = nb;
    end
    if (dv && sz < DEPTH) mQ.push_back(di);
    mCyc++;
    @(posedge clk);
    #1;
  endtask

  // Holds reset for one edge and checks that the handshakes are blocked
  // meanwhile. Then it restarts the model and the observation state.
  task automatic doReset(input bit cv, input bit dv);
    rst        = 1'b1;
    cmd_valid  = cv;
    cmd_code   = 3'd3;
    data_valid = dv;
    data_in    = 8'hFF;
    tx_enable  = 1'b1;
    data_ascii = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready",  cmd_ready,  0);
    checkOutput("rst_data_ready", data_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mCyc   = 0;
    mCur   = 8'h00;
    mBurst = 0;
    mQ.delete();
    acc = 8'h00;
    obs.delete();
    strobeCount = 0;
    firstStrobe = -1;
    acceptCount = 0;
    firstAccept = -1;
  endtask

  task automatic scenIdle();
    int nz;
    doReset(1'b0, 1'b0);
    for (int c = 0; c < 64; c++) applyStimulus(0, 3'd0, 0, 8'h00, 0, 0);
    nz = 0;
    foreach (obs[i]) if (obs[i] != 8'h00) nz++;
    checkOutput("idle_slots",        obs.size(), 8);
    checkOutput("idle_nonzero",      nz, 0);
    checkOutput("idle_strobes",      strobeCount, 8);
    checkOutput("idle_first_strobe", firstStrobe, 7);
  endtask

  task automatic scenCmd();
    doReset(1'b1, 1'b0);
    for (int c = 0; c < 24; c++) applyStimulus(c < 8, 3'd3, 0, 8'h00, 0, 0);
    checkOutput("cmd_accepts",      acceptCount, 1);
    checkOutput("cmd_first_accept", firstAccept, 7);
    checkOutput("cmd_slot0",        obs[0], 8'h00);
    checkOutput("cmd_slot1",        obs[1], 8'h03);
    checkOutput("cmd_slot2",        obs[2], 8'h00);
  endtask

  task automatic scenBurst2();
    doReset(1'b0, 1'b0);
    for (int c = 0; c < 40; c++)
      applyStimulus(0, 3'd0, c < 2, (c == 0) ? 8'hA5 : 8'h3C, 0, 1);
    checkOutput("b2_header", obs[1], 8'h07);
    checkOutput("b2_byte0",  obs[2], 8'hA5);
    checkOutput("b2_byte1",  obs[3], 8'h3C);
    checkOutput("b2_after",  obs[4], 8'h00);
  endtask

  task automatic scenBurst6();
    logic [7:0] d6[6];
    logic [7:0] expd[11];
    d6   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expd = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h05, 8'h08, 8'h55, 8'h66, 8'h00};
    doReset(1'b0, 1'b0);
    for (int c = 0; c < 88; c++)
      applyStimulus(c >= 20 && c <= 47, 3'd5, c < 6, (c < 6) ? d6[c] : 8'h00, 1, 1);
    for (int k = 0; k < 11; k++) checkOutput($sformatf("b6_slot%0d", k), obs[k], expd[k]);
    checkOutput("b6_accepts",      acceptCount, 1);
    checkOutput("b6_first_accept", firstAccept, 47);
  endtask

  task automatic scenFull();
    logic [7:0] expd[15];
    expd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h10, 8'h11, 8'h12,
             8'h13, 8'h07, 8'h14, 8'h15, 8'h16, 8'h17, 8'h00};
    doReset(1'b0, 1'b0);
    for (int c = 0; c < 120; c++) begin
      if (c == 9) begin
        checkOutput("full_count",      fifo_count, 8);
        checkOutput("full_data_ready", data_ready, 0);
      end
      if (c == 39) checkOutput("full_before_pop", data_ready, 0);
      if (c == 40) checkOutput("full_after_pop",  data_ready, 1);
      applyStimulus(0, 3'd0, c < 9, (c < 8) ? 8'(8'h10 + c) : 8'hEE, 0, c >= 24);
    end
    for (int k = 0; k < 15; k++) checkOutput($sformatf("full_slot%0d", k), obs[k], expd[k]);
  endtask

  task automatic scenRst();
    doReset(1'b0, 1'b0);
    for (int c = 0; c < 26; c++)
      applyStimulus(0, 3'd0, c < 3, 8'(8'hB0 + c), 0, 1);
    checkOutput("rst_pre_header", obs[1], 8'h07);
    checkOutput("rst_pre_byte0",  obs[2], 8'hB0);
    checkOutput("rst_pre_state",  frame_state, 1);
    doReset(1'b1, 1'b1);
    checkOutput("rst_serial", serial_out, 0);
    checkOutput("rst_count",  fifo_count, 0);
    checkOutput("rst_state",  frame_state, 0);
    for (int c = 0; c < 24; c++) applyStimulus(c < 8, 3'd6, 0, 8'h00, 0, 1);
    checkOutput("rst_slot0", obs[0], 8'h00);
    checkOutput("rst_slot1", obs[1], 8'h06);
    checkOutput("rst_slot2", obs[2], 8'h00);
  endtask

  task automatic scenTable();
    doReset(1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++) applyStimulus(1, cmdTable[k].code, 0, 8'h00, 0, 0);
    for (int j = 0; j < 8; j++) applyStimulus(0, 3'd0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("table_code%0d", k), obs[k+1], cmdTable[k].expByte);
    checkOutput("table_accepts", acceptCount, 8);
  endtask

  task automatic scenRandom();
    bit te;
    te = 1'b1;
    doReset(1'b0, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 31) == 0) te = ~te;
      if ($urandom_range(0, 699) == 0) begin
        doReset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        applyStimulus($urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)),
                      $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                      $urandom_range(0, 1) == 1, te);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      cmdTable[k].code    = 3'(k);
      cmdTable[k].expByte = (k >= 1 && k <= 6) ? 8'(k) : 8'h00;
    end
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_code   = 3'd0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    data_ascii = 1'b0;
    tx_enable  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] starting directed scenarios");
    scenIdle();
    scenCmd();
    scenBurst2();
    scenBurst6();
    scenFull();
    scenRst();
    scenTable();
    $display("[TB] starting randomized run");
    scenRandom();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/transfer_frame_tx.md
Name: transfer_frame_tx

Overview:
Upstream stage of the transfer center. Serializes link traffic onto the single-bit dataIn line that the transfer center shifts in: MSB-first, one bit per clk, fixed 8-clock byte slots aligned to reset. Carries two kinds of traffic:
- 1-byte buffer-status/control commands (codes 1-6).
- Data bursts: a header byte (7 = binary, 8 = ASCII) followed by payload bytes drained from an internal byte FIFO.
A burst starts only while the downstream ready (readyForTransferOut) is high.

Parameters:
DEPTH, 8, payload FIFO depth in bytes; power of 2, >=2
MAX_BURST, 4, maximum payload bytes following one header; 1..DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_code  in  3  command code; 1..6 legal
cmd_ready  out  1  command accepted this cycle when high with cmd_valid
data_in  in  8  payload byte
data_valid  in  1  payload byte offered
data_ready  out  1  FIFO can accept a byte
data_ascii  in  1  header select: 0 -> 8'd7, 1 -> 8'd8; sampled at header load
tx_enable  in  1  downstream ready for transfer
serial_out  out  1  serial line; drives the transfer center's dataIn
byte_strobe  out  1  high during the last bit (bit_cnt==7) of every slot
frame_state  out  2  00 IDLE, 01 PAYLOAD
fifo_count  out  log2(DEPTH)+1  bytes held in FIFO

Behaviour:
Slot timing:
- bit_cnt is 3-bit, free-running, cleared by rst, +1 every clk, wraps 7->0.
- serial_out = shreg[7].
- On an edge with bit_cnt==7: shreg loads the next byte ("slot load").
- On every other edge: shreg shifts left with 0 fill.
- byte_strobe = (bit_cnt==7).

Reset (rst high at an edge):
- shreg = 0, bit_cnt = 0, state IDLE, FIFO pointers and count = 0, burst counter = 0.
- While rst is high: cmd_ready = 0, data_ready = 0.
- The first slot after reset is 0x00. The first loaded byte appears on serial_out starting 8 clocks after rst deasserts.
- rst mid-burst aborts the burst and discards FIFO contents.

Slot-load decision, IDLE state (checked in this priority order):
1. cmd_valid: load {5'b0, cmd_code}.
   - cmd_ready is high exactly in this cycle (combinational: IDLE && bit_cnt==7).
   - cmd_code 0 or 7: accepted, but 0x00 is transmitted (never a false header).
2. Else tx_enable && fifo_count>0:
   - Load 8'd7 or 8'd8 per data_ascii.
   - Latch burst_rem = min(fifo_count, MAX_BURST).
   - Go to PAYLOAD.
3. Else: load 0x00.

Slot-load decision, PAYLOAD state:
- Load the FIFO head, pop, burst_rem-1.
- When burst_rem reaches 0 on this load, go to IDLE.
- cmd_ready is held 0 for the whole burst.
- tx_enable dropping mid-burst does not abort; the burst completes.
- No header is emitted while fifo_count==0.

FIFO:
- data_ready = !rst && fifo_count<DEPTH.
- Push on data_valid && data_ready.
- Push and pop in the same cycle: count unchanged.
- Pointers wrap modulo DEPTH.
- Bytes are FIFO-ordered; the burst length is fixed at header load, so bytes pushed after the header wait for the next burst.

Test Plan:
- Reset then idle, no requests: serial_out stays 0 for 64 clks; byte_strobe pulses every 8th clk, first at clk 7 after reset.
- cmd_valid with code 3 held from reset: cmd_ready pulses once at clk 7; slot 2 bits are 0,0,0,0,0,0,1,1; then cmd_valid drops and 0x00 slots follow.
- Push 0xA5, 0x3C with tx_enable=1, data_ascii=0: header 0x07, then 0xA5, 0x3C, then 0x00; fifo_count goes 2->1->0 at successive slot loads.
- Push 6 bytes (MAX_BURST=4) with data_ascii=1: 0x08 + 4 bytes, then 0x08 + 2 bytes; cmd_valid raised mid-burst is accepted only after the burst ends.
- Fill 8 bytes with tx_enable=0: data_ready=0 at count 8, a 9th push is ignored, no header is sent; raise tx_enable and data_ready returns 1 after the first pop.
- Assert rst during the 2nd payload byte: serial_out=0 next clk, fifo_count=0, next slot 0x00; a command sent right after reset is framed correctly.
